nios_blink_led_seq: RTL and testbench
=====================================

NIOS_BLINK_LED_SEQ -- requirements
Module: nios_blink_led_seq

Interface
REQ-001 SHALL have parameter PERIOD_W, default 24, width of the step-period counter and PERIOD register.
REQ-002 SHALL have parameter LED_W, default 4, width of the LED pattern written to the LED PIO.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port cfg_address, input, 2, config slave word address.
REQ-006 SHALL have port cfg_chipselect, input, 1, config slave select.
REQ-007 SHALL have port cfg_write_n, input, 1, config slave write strobe, active-low.
REQ-008 SHALL have port cfg_writedata, input, 32, config slave write data.
REQ-009 SHALL have port cfg_readdata, output, 32, config slave read data; combinational, zero-wait-state.
REQ-010 SHALL have port pio_address, output, 2, master address to the LED PIO slave.
REQ-011 SHALL have port pio_chipselect, output, 1, master select to the LED PIO slave.
REQ-012 SHALL have port pio_write_n, output, 1, master write strobe, active-low.
REQ-013 SHALL have port pio_writedata, output, 32, master write data.

Function
REQ-014 SHALL decode four config registers: 0 CTRL, 1 PERIOD, 2 PATTERN, 3 STATUS. A write SHALL occur when cfg_chipselect=1 and cfg_write_n=0.
REQ-015 SHALL define CTRL as follows: bit0 EN, bit1 MODE (0 rotate, 1 binary count), bit2 DIR (0 left/up, 1 right/down). Bits 31:3 SHALL read as 0.
REQ-016 SHALL make PERIOD a PERIOD_W-bit register holding the clk cycles per step. A value of 0 SHALL behave as 1.
REQ-017 SHALL have a write to PATTERN load cur_pat with writedata[LED_W-1:0] and raise a one-shot flag, push_pend. STATUS writes SHALL be ignored.
REQ-018 SHALL map reads as follows:
- CTRL returns the register value.
- PERIOD returns the value zero-extended.
- PATTERN returns cur_pat zero-extended.
- STATUS returns {16'b0, step_cnt[7:0], 3'b0, busy, cur_pat padded to 4 bits}.
REQ-019 SHALL implement an FSM with states IDLE, WAIT and WRITE.
REQ-020 SHALL transition from IDLE to WRITE on the cycle after EN becomes 1, so the current pattern is pushed immediately; EN=0 SHALL hold the FSM in IDLE.
REQ-021 SHALL, in WAIT, increment tick_cnt each cycle. When tick_cnt = max(PERIOD,1)-1, it SHALL clear tick_cnt, advance cur_pat and go to WRITE.
REQ-022 SHALL advance cur_pat in rotate mode as follows: DIR=0 rotates left by 1 (MSB wraps to bit0), and DIR=1 rotates right by 1 (bit0 wraps to MSB).
REQ-023 SHALL advance cur_pat in count mode as follows: DIR=0 gives cur_pat+1 modulo 2^LED_W (all-ones wraps to 0), and DIR=1 gives cur_pat-1 (0 wraps to all-ones).
REQ-024 SHALL hold WRITE for exactly one cycle with pio_chipselect=1, pio_write_n=0, pio_address=0 and pio_writedata={zeros, cur_pat}. It SHALL then go to WAIT and increment the 8-bit step_cnt, which wraps 255 to 0.
REQ-025 SHALL drive pio_chipselect=0, pio_write_n=1, pio_address=0 and pio_writedata=0 outside WRITE.
REQ-026 SHALL assert busy (STATUS bit4) in WAIT and WRITE.
REQ-027 SHALL handle EN cleared while in WAIT by going to IDLE next cycle and clearing tick_cnt, with no further PIO write.
REQ-028 SHALL handle EN cleared while in WRITE by completing the write, then going to IDLE.
REQ-029 SHALL handle a PATTERN write while in WAIT by loading cur_pat, clearing tick_cnt and going to WRITE next cycle, so the new value is pushed unadvanced.
REQ-030 SHALL handle a PATTERN write while in IDLE by loading cur_pat only, with no PIO write; push_pend SHALL be cleared on entry to IDLE.
REQ-031 SHALL give a config write coinciding with the terminal tick priority over the automatic advance: the written pattern is pushed unadvanced.
REQ-032 SHALL have a PERIOD write take effect on the next comparison; if tick_cnt is already ≥ the new PERIOD-1, that SHALL count as terminal on the next cycle.

Reset
REQ-033 SHALL, with reset_n=0 at a clk rising edge, set the following: CTRL=0, PERIOD=0, cur_pat=0, tick_cnt=0, step_cnt=0, push_pend=0, FSM=IDLE.
REQ-034 SHALL drive the PIO outputs to their REQ-025 idle values during and after reset. A write in progress SHALL be aborted, with no strobe on the cycle after reset is sampled.
REQ-035 SHALL make cfg_readdata reflect the reset register values combinationally.

Verification
REQ-036 SHALL cover rotate-left: PATTERN=0x1, PERIOD=3, CTRL=0x1 → PIO writes 0x1, 0x2, 0x4, 0x8, 0x1, each 3 clk apart, and each strobe exactly 1 cycle wide.
REQ-037 SHALL cover count-down wrap: PATTERN=0x0, PERIOD=1, CTRL=0x7 → writes 0x0, 0xF, 0xE on consecutive WRITE cycles, 1 cycle apart between strobes (WAIT=1 cycle); STATUS step_cnt=3.
REQ-038 SHALL cover PERIOD=0 equivalence: PERIOD=0 gives the same write spacing as PERIOD=1.
REQ-039 SHALL cover a mid-WAIT PATTERN write: PERIOD=100, write PATTERN=0x5 at tick 40 → a PIO write of 0x5 two cycles later, and the next write 0xA 100 cycles after that (rotate-left).
REQ-040 SHALL cover disable and reset mid-run:
- Clearing EN in WAIT → no further strobes; STATUS busy=0.
- reset_n=0 asserted during WRITE → strobe drops the next cycle; all registers read 0.
REQ-041 SHALL cover PERIOD shrink: tick_cnt=50, write PERIOD=10 → a write occurs within 2 cycles, and the counter then continues at period 10.

Source files
------------

// File: rtl/nios_blink_led_seq.sv
// LED sequencer: pushes a rotating/counting pattern to an LED PIO through an Avalon-style master write.
// Latency: first PIO write two cycles after EN is written; later writes every PERIOD WAIT cycles plus one WRITE cycle.
// Backpressure: none; config slave is zero-wait-state and the PIO write is a fixed single-cycle strobe.
module nios_blink_led_seq #(
    parameter int PERIOD_W = 24,
    parameter int LED_W    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  cfg_address,
    input  logic        cfg_chipselect,
    input  logic        cfg_write_n,
    input  logic [31:0] cfg_writedata,
    output logic [31:0] cfg_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [PERIOD_W-1:0] P_ONE   = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [LED_W-1:0]    LED_ONE = {{(LED_W-1){1'b0}}, 1'b1};

    state_t               state;
    state_t               state_nxt;
    logic [2:0]           ctrl;
    logic [PERIOD_W-1:0]  period;
    logic [PERIOD_W-1:0]  per_m1;
    logic [PERIOD_W-1:0]  tick_cnt;
    logic [PERIOD_W-1:0]  tick_nxt;
    logic [LED_W-1:0]     cur_pat;
    logic [LED_W-1:0]     adv_pat;
    logic [7:0]           step_cnt;
    logic                 push_pend;
    logic                 advance;
    logic                 busy;
    logic                 cfg_wr;
    logic                 ctrl_wr;
    logic                 per_wr;
    logic                 pat_wr;
    logic                 cfg_wdata_unused;

    wire en   = ctrl[0];
    wire mode = ctrl[1];
    wire dir  = ctrl[2];

    assign cfg_wr  = cfg_chipselect && !cfg_write_n;
    assign ctrl_wr = cfg_wr && (cfg_address == 2'd0);
    assign per_wr  = cfg_wr && (cfg_address == 2'd1);
    assign pat_wr  = cfg_wr && (cfg_address == 2'd2);

    // Only the low bits of the write data are stored; keep the rest referenced.
    assign cfg_wdata_unused = ^cfg_writedata;

    // A zero period behaves as one cycle per step.
    assign per_m1 = (period == '0) ? '0 : (period - P_ONE);
    assign busy   = (state == WAIT) || (state == WRITE);

    // Next pattern for the automatic step, selected by MODE and DIR.
    always_comb begin
        adv_pat = cur_pat;
        case ({mode, dir})
            2'b00:   adv_pat = {cur_pat[LED_W-2:0], cur_pat[LED_W-1]};
            2'b01:   adv_pat = {cur_pat[0], cur_pat[LED_W-1:1]};
            2'b10:   adv_pat = cur_pat + LED_ONE;
            default: adv_pat = cur_pat - LED_ONE;
        endcase
    end

    // Sequencer next state: a pending pattern push wins over the terminal-tick advance.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                tick_nxt = '0;
                if (en) state_nxt = WRITE;
            end
            WAIT: begin
                if (!en) begin
                    state_nxt = IDLE;
                    tick_nxt  = '0;
                end else if (push_pend) begin
                    state_nxt = WRITE;
                    tick_nxt  = '0;
                end else if (tick_cnt >= per_m1) begin
                    // >= so a shrunken PERIOD terminates right away
                    state_nxt = WRITE;
                    tick_nxt  = '0;
                    advance   = 1'b1;
                end else begin
                    tick_nxt = tick_cnt + P_ONE;
                end
            end
            WRITE: begin
                state_nxt = en ? WAIT : IDLE;
            end
            default: begin
                state_nxt = IDLE;
                tick_nxt  = '0;
            end
        endcase
    end

    // State, counters and config registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            ctrl      <= 3'b000;
            period    <= '0;
            cur_pat   <= '0;
            tick_cnt  <= '0;
            step_cnt  <= 8'd0;
            push_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            if (ctrl_wr) ctrl   <= cfg_writedata[2:0];
            if (per_wr)  period <= cfg_writedata[PERIOD_W-1:0];
            // A written pattern overrides the advance that would happen on the same edge.
            if (pat_wr)       cur_pat <= cfg_writedata[LED_W-1:0];
            else if (advance) cur_pat <= adv_pat;
            // push_pend is consumed by the WRITE it triggers; a write during WRITE queues another push.
            if (state_nxt == IDLE)                           push_pend <= 1'b0;
            else if (pat_wr)                                 push_pend <= 1'b1;
            else if (state == WRITE || state_nxt == WRITE)  push_pend <= 1'b0;
            if (state == WRITE) step_cnt <= step_cnt + 8'd1;
        end
    end

    // PIO master: single-cycle strobe in WRITE, forced idle while reset is held.
    assign pio_chipselect = reset_n && (state == WRITE);
    assign pio_write_n    = !pio_chipselect;
    assign pio_address    = 2'b00;
    assign pio_writedata  = pio_chipselect ? 32'(cur_pat) : 32'h0;

    // Zero-wait-state config read mux.
    always_comb begin
        cfg_readdata = 32'h0;
        case (cfg_address)
            2'd0:    cfg_readdata = {29'b0, ctrl};
            2'd1:    cfg_readdata = 32'(period);
            2'd2:    cfg_readdata = 32'(cur_pat);
            default: cfg_readdata = {16'b0, step_cnt, 3'b0, busy, 4'b0} | (32'(cur_pat) & 32'hF);
        endcase
    end

endmodule

// File: tb/tb_nios_blink_led_seq.sv
// Directed bench for nios_blink_led_seq: register table plus hand-timed sequencing scenarios.
// Latency: strobe timing is checked cycle-exactly against a free-running cycle counter.
// Backpressure: none; PIO strobes are captured by a passive monitor.
module tb_nios_blink_led_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  cfg_address;
    logic        cfg_chipselect;
    logic        cfg_write_n;
    logic [31:0] cfg_writedata;
    logic [31:0] cfg_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;

    nios_blink_led_seq #(.PERIOD_W(24), .LED_W(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_address    (cfg_address),
        .cfg_chipselect (cfg_chipselect),
        .cfg_write_n    (cfg_write_n),
        .cfg_writedata  (cfg_writedata),
        .cfg_readdata   (cfg_readdata),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int wr_cyc = 0;
    int q_cyc[$];
    logic [31:0] q_dat[$];

    typedef struct {
        logic        cs;
        logic        wn;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    logic [31:0] rot_exp[5] = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1};
    logic [31:0] dn_exp[3]  = '{32'h0, 32'hF, 32'hE};
    logic [31:0] up_exp[4]  = '{32'h0, 32'h1, 32'h2, 32'h3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Passive strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
            q_cyc.push_back(cyc);
            q_dat.push_back(pio_writedata);
            chk("strobe_addr", {30'b0, pio_address}, 32'h0);
        end
    end

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        wr_cyc         = cyc;
        cfg_address    = a;
        cfg_writedata  = d;
        cfg_chipselect = 1'b1;
        cfg_write_n    = 1'b0;
        @(posedge clk);
        #1;
        cfg_chipselect = 1'b0;
        cfg_write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        cfg_address = a;
        #1;
        d = cfg_readdata;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_strobes(input int n, input int budget, input string name);
        int k = 0;
        while (q_cyc.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(name, q_cyc.size(), n);
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        q_cyc.delete();
        q_dat.delete();
    endtask

    logic [31:0] r;
    int w;
    int p;
    int n0;

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        cfg_address    = 2'd0;
        cfg_chipselect = 1'b0;
        cfg_write_n    = 1'b1;
        cfg_writedata  = 32'h0;

        vecs[0] = '{1'b1, 1'b0, 2'd0, 32'hFFFF_FFF6, 2'd0, 32'h0000_0006};
        vecs[1] = '{1'b1, 1'b0, 2'd1, 32'hAB12_3456, 2'd1, 32'h0012_3456};
        vecs[2] = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFF9, 2'd2, 32'h0000_0009};
        vecs[3] = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0009};
        vecs[4] = '{1'b0, 1'b0, 2'd0, 32'h0000_0001, 2'd0, 32'h0000_0006};
        vecs[5] = '{1'b1, 1'b1, 2'd2, 32'h0000_0003, 2'd2, 32'h0000_0009};
        vecs[6] = '{1'b1, 1'b0, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};
        vecs[7] = '{1'b1, 1'b0, 2'd1, 32'h0000_0000, 2'd1, 32'h0000_0000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pio_cs", {31'b0, pio_chipselect}, 32'h0);
        chk("rst_pio_wn", {31'b0, pio_write_n}, 32'h1);
        chk("rst_pio_dat", pio_writedata, 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), r);
            chk($sformatf("rst_reg%0d", a), r, 32'h0);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Register decode table, sequencer disabled
        for (int i = 0; i < 8; i++) begin
            cfg_address    = vecs[i].addr;
            cfg_writedata  = vecs[i].wdata;
            cfg_chipselect = vecs[i].cs;
            cfg_write_n    = vecs[i].wn;
            @(posedge clk);
            #1;
            cfg_chipselect = 1'b0;
            cfg_write_n    = 1'b1;
            rd(vecs[i].raddr, r);
            chk($sformatf("vec%0d", i), r, vecs[i].exp);
        end
        chk("idle_no_strobe", q_cyc.size(), 0);

        // Rotate left, PERIOD=3: one WRITE cycle then three WAIT cycles per step
        reset_dut();
        cfg_write(2'd2, 32'h1);
        cfg_write(2'd1, 32'd3);
        cfg_write(2'd0, 32'h1);
        p = wr_cyc;
        wait_strobes(5, 60, "rot_count");
        chk("rot_en_lat", q_cyc[0] - p, 2);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rot_dat%0d", i), q_dat[i], rot_exp[i]);
            if (i > 0) chk($sformatf("rot_gap%0d", i), q_cyc[i] - q_cyc[i-1], 4);
        end
        rd(2'd3, r);
        chk("rot_status_busy", r, 32'h0000_0411);
        cfg_write(2'd0, 32'h0);
        repeat (12) @(posedge clk);
        #1;
        chk("dis_no_strobe", q_cyc.size(), 5);
        rd(2'd3, r);
        chk("dis_status", r, 32'h0000_0501);

        // Count down from 0 with PERIOD=1; disable during the third WRITE
        reset_dut();
        cfg_write(2'd2, 32'h0);
        cfg_write(2'd1, 32'd1);
        cfg_write(2'd0, 32'h7);
        wait_strobes(3, 30, "dn_count");
        cfg_write(2'd0, 32'h6);
        repeat (6) @(posedge clk);
        #1;
        chk("dn_stop", q_cyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dn_dat%0d", i), q_dat[i], dn_exp[i]);
            if (i > 0) chk($sformatf("dn_gap%0d", i), q_cyc[i] - q_cyc[i-1], 2);
        end
        rd(2'd3, r);
        chk("dn_status", r, 32'h0000_030E);

        // PERIOD=0 spaces strobes like PERIOD=1
        reset_dut();
        cfg_write(2'd2, 32'h0);
        cfg_write(2'd1, 32'd0);
        cfg_write(2'd0, 32'h3);
        wait_strobes(4, 30, "p0_count");
        cfg_write(2'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("p0_dat%0d", i), q_dat[i], up_exp[i]);
            if (i > 0) chk($sformatf("p0_gap%0d", i), q_cyc[i] - q_cyc[i-1], 2);
        end

        // PATTERN write mid-WAIT, then one coinciding with the terminal tick
        reset_dut();
        cfg_write(2'd2, 32'h1);
        cfg_write(2'd1, 32'd100);
        cfg_write(2'd0, 32'h1);
        wait_strobes(1, 20, "mw_first");
        w = q_cyc[0];
        wait_cyc(w + 41);
        cfg_write(2'd2, 32'h5);
        p = wr_cyc;
        wait_strobes(2, 20, "mw_push");
        chk("mw_push_lat", q_cyc[1] - p, 2);
        chk("mw_push_dat", q_dat[1], 32'h5);
        wait_strobes(3, 150, "mw_next");
        chk("mw_next_gap", q_cyc[2] - q_cyc[1], 101);
        chk("mw_next_dat", q_dat[2], 32'hA);
        wait_cyc(q_cyc[2] + 100);
        cfg_write(2'd2, 32'h3);
        wait_strobes(4, 20, "term_push");
        chk("term_gap", q_cyc[3] - q_cyc[2], 101);
        chk("term_dat", q_dat[3], 32'h3);
        wait_strobes(5, 150, "term_next");
        chk("term_next_gap", q_cyc[4] - q_cyc[3], 101);
        chk("term_next_dat", q_dat[4], 32'h6);
        cfg_write(2'd0, 32'h0);

        // PERIOD shrink at tick 50, then reset asserted during a WRITE
        reset_dut();
        cfg_write(2'd2, 32'h1);
        cfg_write(2'd1, 32'd100);
        cfg_write(2'd0, 32'h1);
        wait_strobes(1, 20, "sh_first");
        w = q_cyc[0];
        wait_cyc(w + 51);
        cfg_write(2'd1, 32'd10);
        p = wr_cyc;
        wait_strobes(2, 20, "sh_push");
        chk("sh_lat", q_cyc[1] - p, 2);
        chk("sh_dat", q_dat[1], 32'h2);
        wait_strobes(3, 40, "sh_next");
        chk("sh_gap", q_cyc[2] - q_cyc[1], 11);
        chk("sh_next_dat", q_dat[2], 32'h4);
        wait_strobes(4, 40, "rw_strobe");
        chk("rw_dat", q_dat[3], 32'h8);
        n0 = q_cyc.size();
        reset_n = 1'b0;
        #1;
        chk("rw_cs_during", {31'b0, pio_chipselect}, 32'h0);
        @(posedge clk);
        #1;
        chk("rw_cs_after", {31'b0, pio_chipselect}, 32'h0);
        chk("rw_wn_after", {31'b0, pio_write_n}, 32'h1);
        chk("rw_dat_after", pio_writedata, 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), r);
            chk($sformatf("rw_reg%0d", a), r, 32'h0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rw_no_strobe", q_cyc.size(), n0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
